// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer for the multi-core systolic matmul C = I x W.
// It walks the output tiles row-major, issues BRAM reads per inner step, waits for results and writes them out.
module matmul_tile_scheduler #(
   parameter int BLOCK_SIZE        = 2,
   parameter int NUM_CORES         = 2,
   parameter int INNER_DIMENSION   = 4,
   parameter int W_OUTER_DIMENSION = 6,
   parameter int I_OUTER_DIMENSION = 8,
   parameter int IN_ADDR_W         = 14,
   parameter int WB_ADDR_W         = 12,
   parameter int OUT_ADDR_W        = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic                  in_en,
   output logic [IN_ADDR_W-1:0]  in_addr,
   output logic                  wb_en,
   output logic [WB_ADDR_W-1:0]  wb_addr,
   output logic                  acc_first,
   output logic                  acc_last,
   input  logic                  core_ready,
   input  logic                  core_valid,
   output logic                  out_we,
   output logic [OUT_ADDR_W-1:0] out_addr,
   output logic                  proto_err
);

   localparam int ROW_C   = I_OUTER_DIMENSION / BLOCK_SIZE;
   localparam int COL_C   = W_OUTER_DIMENSION / BLOCK_SIZE;
   localparam int K_STEPS = INNER_DIMENSION / (BLOCK_SIZE * NUM_CORES);
   localparam int RW      = (ROW_C > 1) ? $clog2(ROW_C) : 1;
   localparam int CW      = (COL_C > 1) ? $clog2(COL_C) : 1;
   localparam int KW      = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;

   localparam logic [RW-1:0]         R_LAST = RW'(ROW_C - 1);
   localparam logic [CW-1:0]         C_LAST = CW'(COL_C - 1);
   localparam logic [KW-1:0]         K_LAST = KW'(K_STEPS - 1);
   localparam logic [IN_ADDR_W-1:0]  K_IN   = IN_ADDR_W'(K_STEPS);
   localparam logic [WB_ADDR_W-1:0]  K_WB   = WB_ADDR_W'(K_STEPS);
   localparam logic [OUT_ADDR_W-1:0] COLS   = OUT_ADDR_W'(COL_C);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [RW-1:0]           r_q, r_d;
   logic [CW-1:0]           c_q, c_d;
   logic [KW-1:0]           k_q, k_d;
   logic [IN_ADDR_W-1:0]    in_addr_q, in_addr_d;
   logic [WB_ADDR_W-1:0]    wb_addr_q, wb_addr_d;
   logic [OUT_ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic                    proto_err_q, proto_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         r_q         <= '0;
         c_q         <= '0;
         k_q         <= '0;
         in_addr_q   <= '0;
         wb_addr_q   <= '0;
         out_addr_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         c_q         <= c_d;
         k_q         <= k_d;
         in_addr_q   <= in_addr_d;
         wb_addr_q   <= wb_addr_d;
         out_addr_q  <= out_addr_d;
         proto_err_q <= proto_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      c_d         = c_q;
      k_d         = k_q;
      proto_err_d = proto_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d     = '0;
               c_d     = '0;
               k_d     = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (core_ready) begin
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  state_d = S_DRAIN;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (core_valid) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (c_q == C_LAST) begin
               c_d = '0;
               r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            end else begin
               c_d = c_q + 1'b1;
            end
            state_d = (c_q == C_LAST && r_q == R_LAST) ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // An accepted start wins over a stray core_valid in the same cycle.
      if (state_q == S_IDLE && start) begin
         proto_err_d = 1'b0;
      end else if (core_valid && state_q != S_DRAIN) begin
         proto_err_d = 1'b1;
      end

      // Addresses follow the next counter values so they are valid as soon as the state is entered.
      in_addr_d  = IN_ADDR_W'(r_d) * K_IN + IN_ADDR_W'(k_d);
      wb_addr_d  = WB_ADDR_W'(c_d) * K_WB + WB_ADDR_W'(k_d);
      out_addr_d = OUT_ADDR_W'(r_d) * COLS + OUT_ADDR_W'(c_d);
   end

   assign ready     = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign in_en     = (state_q == S_ISSUE);
   assign wb_en     = (state_q == S_ISSUE);
   assign acc_first = (state_q == S_ISSUE) && (k_q == '0);
   assign acc_last  = (state_q == S_ISSUE) && (k_q == K_LAST);
   assign out_we    = (state_q == S_WRITE);
   assign in_addr   = in_addr_q;
   assign wb_addr   = wb_addr_q;
   assign out_addr  = out_addr_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench: two scheduler instances (K_STEPS = 1 and 4) against a tile/step counting model.
module tb_matmul_tile_scheduler;

   localparam int NI    = 2;
   localparam int COLC  = 3;
   localparam int TILES = 12;
   localparam int BOUND = 3000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic start[NI], coreReady[NI], cvAuto[NI], cvForce[NI];
   logic ready[NI], busy[NI], done[NI], inEn[NI], wbEn[NI];
   logic accFirst[NI], accLast[NI], outWe[NI], protoErr[NI];
   logic [13:0] inAddr[NI];
   logic [11:0] wbAddr[NI];
   logic [7:0]  outAddr[NI];

   int  errors = 0;
   int  checks = 0;
   int  dly[NI];
   bit  hold[NI];
   bit  lastAcc[NI];
   int  wrCnt[NI], doneCnt[NI], issCnt[NI];
   int  inSeqA[$], wbSeqA[$], inSeqB[$], wbSeqB[$];

   task automatic checkOutput(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL u%0d %s: got %0d expected %0d at %0t", g, name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int KS = (g == 0) ? 1 : 4;

      matmul_tile_scheduler #(.INNER_DIMENSION(KS * 4)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start[g]),
         .ready      (ready[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .in_en      (inEn[g]),
         .in_addr    (inAddr[g]),
         .wb_en      (wbEn[g]),
         .wb_addr    (wbAddr[g]),
         .acc_first  (accFirst[g]),
         .acc_last   (accLast[g]),
         .core_ready (coreReady[g]),
         .core_valid (cvAuto[g] | cvForce[g]),
         .out_we     (outWe[g]),
         .out_addr   (outAddr[g]),
         .proto_err  (protoErr[g])
      );

      // Model: ph 0 idle, 1 issuing step kk of tile, 2 waiting for result, 3 writing, 4 done.
      int  ph   = 0;
      int  tile = 0;
      int  kk   = 0;
      bit  perr = 0;
      int  cnt  = 0;
      bit  pend = 0;

      always @(negedge clk) begin
         bit cv;
         cv = cvAuto[g] | cvForce[g];
         if (!rst_n) begin
            ph = 0; tile = 0; kk = 0; perr = 0;
            checkOutput(g, "rst_in_addr", inAddr[g], 0);
            checkOutput(g, "rst_wb_addr", wbAddr[g], 0);
            checkOutput(g, "rst_out_addr", outAddr[g], 0);
         end
         checkOutput(g, "ready", ready[g], ph == 0);
         checkOutput(g, "busy", busy[g], ph != 0);
         checkOutput(g, "done", done[g], ph == 4);
         checkOutput(g, "in_en", inEn[g], ph == 1);
         checkOutput(g, "wb_en", wbEn[g], ph == 1);
         checkOutput(g, "acc_first", accFirst[g], ph == 1 && kk == 0);
         checkOutput(g, "acc_last", accLast[g], ph == 1 && kk == KS - 1);
         checkOutput(g, "out_we", outWe[g], ph == 3);
         checkOutput(g, "proto_err", protoErr[g], perr);
         if (ph == 1) begin
            checkOutput(g, "in_addr", inAddr[g], (tile / COLC) * KS + kk);
            checkOutput(g, "wb_addr", wbAddr[g], (tile % COLC) * KS + kk);
         end
         if (ph == 3) begin
            checkOutput(g, "out_addr", outAddr[g], tile);
         end
         if (rst_n) begin
            if (inEn[g] && coreReady[g]) begin
               issCnt[g]++;
               if (g == 0) begin
                  inSeqA.push_back(int'(inAddr[g])); wbSeqA.push_back(int'(wbAddr[g]));
               end else begin
                  inSeqB.push_back(int'(inAddr[g])); wbSeqB.push_back(int'(wbAddr[g]));
               end
            end
            if (outWe[g]) wrCnt[g]++;
            if (done[g]) doneCnt[g]++;
            if (ph == 0 && start[g]) perr = 0;
            else if (cv && ph != 2) perr = 1;
            case (ph)
               0: if (start[g]) begin ph = 1; tile = 0; kk = 0; end
               1: if (coreReady[g]) begin
                     if (kk == KS - 1) begin kk = 0; ph = 2; lastAcc[g] = 1; end
                     else kk++;
                  end
               2: if (cv) ph = 3;
               3: begin tile++; ph = (tile == TILES) ? 4 : 1; end
               default: ph = 0;
            endcase
         end
      end

      // Core stand-in: returns a tile result dly cycles into the drain, unless held off.
      always @(posedge clk) begin
         #1;
         cvAuto[g] = 1'b0;
         if (!rst_n) begin
            pend = 0;
            lastAcc[g] = 0;
         end else begin
            if (pend) begin
               if (cnt <= 1) begin
                  if (!hold[g]) begin cvAuto[g] = 1'b1; pend = 0; end
               end else begin
                  cnt--;
               end
            end
            if (lastAcc[g]) begin pend = 1; cnt = dly[g]; lastAcc[g] = 0; end
         end
      end
   end

   task automatic applyStimulus(input int g);
      issCnt[g] = 0; wrCnt[g] = 0; doneCnt[g] = 0;
      if (g == 0) begin inSeqA.delete(); wbSeqA.delete(); end
      else begin inSeqB.delete(); wbSeqB.delete(); end
      @(posedge clk); #1 start[g] = 1'b1;
      @(posedge clk); #1 start[g] = 1'b0;
   endtask

   // kind 0: issue with acc_first, 1: issue with acc_last, 2: done, 3: out_we at out_addr == val
   task automatic waitEvent(input int g, input int kind, input int val, input string name);
      bit hit;
      hit = 0;
      for (int n = 0; n < BOUND && !hit; n++) begin
         @(negedge clk);
         case (kind)
            0: hit = inEn[g] && accFirst[g];
            1: hit = inEn[g] && accLast[g];
            2: hit = done[g];
            default: hit = outWe[g] && (int'(outAddr[g]) == val);
         endcase
      end
      checkOutput(g, name, hit, 1);
   endtask

   int expIn[TILES] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
   int expWb[TILES] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
   int quiet, busyCnt;

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         start[i] = 0; coreReady[i] = 1; cvAuto[i] = 0; cvForce[i] = 0;
         dly[i] = 2; hold[i] = 0; lastAcc[i] = 0;
         wrCnt[i] = 0; doneCnt[i] = 0; issCnt[i] = 0;
      end
      repeat (3) @(negedge clk);
      checkOutput(0, "reset_ready", ready[0], 1);
      checkOutput(0, "reset_busy", busy[0], 0);
      checkOutput(1, "reset_in_en", inEn[1], 0);
      @(posedge clk); #1 rst_n = 1'b1;

      $display("[TB] test 1: K_STEPS=1 full run");
      applyStimulus(0);
      waitEvent(0, 2, 0, "t1_done_seen");
      repeat (2) @(negedge clk);
      checkOutput(0, "t1_writes", wrCnt[0], 12);
      checkOutput(0, "t1_dones", doneCnt[0], 1);
      checkOutput(0, "t1_issues", issCnt[0], 12);
      for (int i = 0; i < TILES; i++) begin
         checkOutput(0, "t1_in_seq", inSeqA[i], expIn[i]);
         checkOutput(0, "t1_wb_seq", wbSeqA[i], expWb[i]);
      end
      checkOutput(0, "t1_proto_err", protoErr[0], 0);

      $display("[TB] tests 2-4: K_STEPS=4 with stall, late start, stray core_valid");
      applyStimulus(1);
      waitEvent(1, 3, 2, "t4_tile2_write");
      waitEvent(1, 1, 0, "t4_tile3_last");
      @(posedge clk); #1 start[1] = 1'b1;
      @(posedge clk); #1 start[1] = 1'b0;
      checkOutput(1, "t4_busy_after_start", busy[1], 1);
      waitEvent(1, 0, 0, "t3_tile4_first");
      @(posedge clk);
      @(posedge clk); #1 coreReady[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput(1, "t3_stall_in", inAddr[1], 6);
         checkOutput(1, "t3_stall_wb", wbAddr[1], 6);
      end
      @(posedge clk); #1 coreReady[1] = 1'b1;
      waitEvent(1, 0, 0, "t4_tile5_first");
      @(posedge clk); #1 cvForce[1] = 1'b1;
      @(posedge clk); #1 cvForce[1] = 1'b0;
      waitEvent(1, 2, 0, "t2_done_seen");
      repeat (2) @(negedge clk);
      checkOutput(1, "t2_writes", wrCnt[1], 12);
      checkOutput(1, "t2_dones", doneCnt[1], 1);
      checkOutput(1, "t3_issues", issCnt[1], 48);
      for (int i = 0; i < 4; i++) begin
         checkOutput(1, "t2_tile5_in", inSeqB[20 + i], 4 + i);
         checkOutput(1, "t2_tile5_wb", wbSeqB[20 + i], 8 + i);
      end
      checkOutput(1, "t4_proto_err_held", protoErr[1], 1);
      applyStimulus(1);
      @(negedge clk);
      checkOutput(1, "t4_proto_err_cleared", protoErr[1], 0);
      waitEvent(1, 2, 0, "t4_rerun_done");

      $display("[TB] test 5: reset during write of tile 6");
      applyStimulus(0);
      waitEvent(0, 3, 6, "t5_tile6_write");
      #1 rst_n = 1'b0;
      #1;
      checkOutput(0, "t5_async_out_we", outWe[0], 0);
      checkOutput(0, "t5_async_ready", ready[0], 1);
      checkOutput(0, "t5_async_busy", busy[0], 0);
      checkOutput(0, "t5_async_out_addr", outAddr[0], 0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      applyStimulus(0);
      @(negedge clk);
      checkOutput(0, "t5_restart_in_en", inEn[0], 1);
      checkOutput(0, "t5_restart_in", inAddr[0], 0);
      checkOutput(0, "t5_restart_wb", wbAddr[0], 0);
      waitEvent(0, 2, 0, "t5_done_seen");
      repeat (2) @(negedge clk);
      checkOutput(0, "t5_writes", wrCnt[0], 12);

      $display("[TB] test 6: 100-cycle drain");
      hold[0] = 1;
      applyStimulus(0);
      waitEvent(0, 1, 0, "t6_first_last");
      quiet = 0; busyCnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (outWe[0] || inEn[0]) quiet++;
         if (busy[0]) busyCnt++;
      end
      checkOutput(0, "t6_quiet_drain", quiet, 0);
      checkOutput(0, "t6_busy_drain", busyCnt, 100);
      hold[0] = 0;
      waitEvent(0, 3, 0, "t6_write0");
      waitEvent(0, 2, 0, "t6_done_seen");
      repeat (2) @(negedge clk);
      checkOutput(0, "t6_writes", wrCnt[0], 12);
      checkOutput(0, "t6_dones", doneCnt[0], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
